hms_time_keeper: RTL and testbench
==================================

Name: hms_time_keeper

Overview:
- Timekeeping core that counts seconds, minutes and hours.
- Drives the binary curHour bus consumed by the hourly chime/indicator block (time_set).
- Includes a small key-driven set-time state machine.
- Sits between the debounced key front-end and the display/chime logic.

Parameters:
- TICK_DIV, 50000000: clk cycles per second. Minimum 2; benches use 4.
- HOUR_MAX, 23: last hour value before wrap to 0.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- run_en  input  1  enables timekeeping in RUN state
- mode_key  input  1  one-cycle pulse, already debounced; advances set state
- inc_key  input  1  one-cycle pulse, already debounced; increments the selected field
- curHour  output  8  current hour, binary 0..HOUR_MAX
- curMin  output  8  current minute, binary 0..59
- curSec  output  8  current second, binary 0..59
- set_state  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN
- sec_tick  output  1  one-cycle pulse per counted second
- hour_strobe  output  1  one-cycle pulse at top of hour, time-driven only

Behaviour:
- Reset, asynchronous: state RUN; prescaler 0; curHour, curMin, curSec = 0; sec_tick = 0; hour_strobe = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 only when state==RUN and run_en=1.
  - Holds its value when run_en=0 in RUN.
  - Forced to 0 in both SET states.
- sec_tick is registered. It is high for exactly the cycle after the prescaler wraps TICK_DIV-1 -> 0.
- Counter updates happen on the same edge that raises sec_tick:
  - curSec increments; 59 -> 0 carries into curMin.
  - curMin 59 -> 0 carries into curHour.
  - curHour HOUR_MAX -> 0 wraps.
  - Latency from prescaler terminal count to visible new value is 1 cycle.
- hour_strobe is high in the same cycle as the sec_tick whose update produced curMin=0 and curSec=0 from 59:59. It is never raised by set edits.
- FSM transitions:
  - RUN --mode_key--> SET_HOUR
  - SET_HOUR --mode_key--> SET_MIN
  - SET_MIN --mode_key--> RUN. On this transition curSec := 0 and prescaler := 0, so the first sec_tick follows TICK_DIV cycles after the exit edge.
- Key handling by state:
  - SET_HOUR: inc_key gives curHour+1, wrapping HOUR_MAX -> 0. No carry.
  - SET_MIN: inc_key gives curMin+1, wrapping 59 -> 0. No carry into hour.
  - SET states: curSec is frozen and sec_tick stays 0.
  - RUN: inc_key is ignored.
- Simultaneous mode_key and inc_key: mode_key wins; the increment is dropped.
- Reset asserted mid-set returns to RUN with time 00:00:00.
- run_en deassert in RUN freezes time and the prescaler; re-assert resumes from the held prescaler count.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package clock_pkg holds:
  - set-state encoding constants (ST_RUN=0, ST_SET_HOUR=1, ST_SET_MIN=2)
  - SEC_MAX=59, MIN_MAX=59
  - the 8-bit time field width
- One sub-module, tick_divider:
  - parameter TICK_DIV
  - inputs clk, rst, en, clr
  - output tick
- The parent holds the FSM and the H/M/S counters.

Test Plan (TICK_DIV=4):
- Reset then run_en=1 for 12 cycles -> sec_tick pulses 3 times, 4 cycles apart; curSec=3; curMin=0; curHour=0.
- Preload via set mode to 13:59, exit, run 60 ticks -> at the 59:59 -> 00:00 tick, curHour=14, curMin=0, curSec=0, and hour_strobe is high for exactly that one cycle.
- Set hour to 23, minute to 59, exit, run 60 ticks -> curHour wraps to 0; hour_strobe pulses once.
- In SET_HOUR issue 25 inc_key pulses from 0 -> curHour=1; curMin unchanged; sec_tick stays 0 throughout.
- Same-cycle mode_key and inc_key in SET_MIN with curMin=10 -> set_state=0, curMin=10, curSec=0; next sec_tick arrives 4 cycles later.
- Assert rst mid-SET_MIN with time 07:33 -> all outputs 0 and set_state=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared set-state encoding, field limits and time field width for the H/M/S timekeeper.
package clock_pkg;
  localparam int TW = 8;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } set_state_e;
  localparam logic [TW-1:0] SEC_MAX = TW'(59);
  localparam logic [TW-1:0] MIN_MAX = TW'(59);
endpackage

// File: rtl/tick_divider.sv
// tick_divider: seconds prescaler counting 0..TICK_DIV-1.
// Ports: clk, rst (async, active-high), en (count enable), clr (force count to 0),
// tick (high while the counter sits at TICK_DIV-1 and is about to wrap).
module tick_divider #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = TICK_DIV > 2 ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] cnt_q, cnt_d;
  // tick is the wrap condition itself; the parent registers it so its
  // counters update on the same edge that raises sec_tick.
  assign tick = en && !clr && cnt_q == LAST;
  always_comb cnt_d = clr ? '0 : !en ? cnt_q : cnt_q == LAST ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/hms_time_keeper.sv
// hms_time_keeper: hours/minutes/seconds timekeeper with a key-driven set-time FSM.
// Ports: clk, rst (async, active-high), run_en (count enable in RUN),
// mode_key/inc_key (debounced one-cycle pulses), curHour/curMin/curSec (binary time),
// set_state (0 RUN, 1 SET_HOUR, 2 SET_MIN), sec_tick (per counted second),
// hour_strobe (top of hour reached by counting, never by edits).
module hms_time_keeper
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int HOUR_MAX = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run_en,
  input  logic          mode_key,
  input  logic          inc_key,
  output logic [TW-1:0] curHour,
  output logic [TW-1:0] curMin,
  output logic [TW-1:0] curSec,
  output logic [1:0]    set_state,
  output logic          sec_tick,
  output logic          hour_strobe
);
  localparam logic [TW-1:0] HMAX = TW'(HOUR_MAX);
  set_state_e state_q, state_d;
  logic [TW-1:0] hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic tick_q, tick_d, strobe_q, strobe_d, tick;
  // A mode_key edge clears the prescaler as well, so no second can be
  // counted on the edge that leaves RUN.
  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (run_en && state_q == ST_RUN),
    .clr  (state_q != ST_RUN || mode_key),
    .tick (tick)
  );
  always_comb begin
    state_d  = state_q;
    hour_d   = hour_q;
    min_d    = min_q;
    sec_d    = sec_q;
    tick_d   = tick;
    strobe_d = tick && sec_q == SEC_MAX && min_q == MIN_MAX;
    if (mode_key) begin
      state_d = state_q == ST_RUN ? ST_SET_HOUR : state_q == ST_SET_HOUR ? ST_SET_MIN : ST_RUN;
      if (state_q == ST_SET_MIN) sec_d = '0;
    end else if (tick) begin
      sec_d = sec_q == SEC_MAX ? '0 : sec_q + TW'(1);
      if (sec_q == SEC_MAX) begin
        min_d = min_q == MIN_MAX ? '0 : min_q + TW'(1);
        if (min_q == MIN_MAX) hour_d = hour_q == HMAX ? '0 : hour_q + TW'(1);
      end
    end else if (inc_key && state_q == ST_SET_HOUR) begin
      hour_d = hour_q == HMAX ? '0 : hour_q + TW'(1);
    end else if (inc_key && state_q == ST_SET_MIN) begin
      min_d = min_q == MIN_MAX ? '0 : min_q + TW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= ST_RUN;
      hour_q   <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      tick_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hour_q   <= hour_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      tick_q   <= tick_d;
      strobe_q <= strobe_d;
    end
  assign curHour     = hour_q;
  assign curMin      = min_q;
  assign curSec      = sec_q;
  assign set_state   = state_q;
  assign sec_tick    = tick_q;
  assign hour_strobe = strobe_q;
endmodule

// File: tb/tb_hms_time_keeper.sv
// tb_hms_time_keeper: directed stimulus against a seconds-of-day model, checked every cycle.
module tb_hms_time_keeper;
  localparam int TD = 4;
  localparam int HM = 23;
  localparam int DAY = (HM + 1) * 3600;
  logic clk = 1'b0, rst = 1'b1, run_en = 1'b0, mode_key = 1'b0, inc_key = 1'b0;
  logic [7:0] curHour, curMin, curSec;
  logic [1:0] set_state;
  logic sec_tick, hour_strobe;
  int vectors = 0, miscompares = 0;
  int tsec = 0, st = 0, pre = 0;
  bit e_tick = 0, e_strobe = 0;
  bit done = 0;

  hms_time_keeper #(.TICK_DIV(TD), .HOUR_MAX(HM)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .mode_key(mode_key), .inc_key(inc_key),
    .curHour(curHour), .curMin(curMin), .curSec(curSec), .set_state(set_state),
    .sec_tick(sec_tick), .hour_strobe(hour_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time is one seconds-of-day integer; fields are derived by division.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      tsec = 0; st = 0; pre = 0; e_tick = 0; e_strobe = 0;
    end else begin
      e_tick = 0; e_strobe = 0;
      if (mode_key) begin
        if (st == 2) tsec = tsec - tsec % 60;
        st = (st + 1) % 3;
        pre = 0;
      end else if (st == 0) begin
        if (run_en) begin
          if (pre == TD - 1) begin
            pre = 0;
            e_tick = 1;
            e_strobe = (tsec % 3600 == 3599);
            tsec = (tsec + 1) % DAY;
          end else pre++;
        end
      end else if (inc_key && st == 1) begin
        tsec = ((tsec / 3600 + 1) % (HM + 1)) * 3600 + tsec % 3600;
      end else if (inc_key && st == 2) begin
        tsec = (tsec / 3600) * 3600 + (((tsec / 60) % 60 + 1) % 60) * 60 + tsec % 60;
      end
    end
  end

  always @(negedge clk) if (!done) begin
    chk("hour", curHour, tsec / 3600);
    chk("min", curMin, (tsec / 60) % 60);
    chk("sec", curSec, tsec % 60);
    chk("state", set_state, st);
    chk("sec_tick", sec_tick, e_tick);
    chk("hour_strobe", hour_strobe, e_strobe);
  end

  task automatic press(input bit m, input bit i);
    @(negedge clk);
    mode_key = m; inc_key = i;
    @(negedge clk);
    mode_key = 0; inc_key = 0;
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) press(0, 1);
  endtask

  task automatic run_watch(input int n, output int ticks, output int strobes,
                           output int h, output int m, output int s);
    ticks = 0; strobes = 0; h = -1; m = -1; s = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (sec_tick) ticks++;
      if (hour_strobe) begin
        strobes++; h = curHour; m = curMin; s = curSec;
      end
    end
  endtask

  initial begin
    int t, sb, h, m, s;
    #12;
    @(negedge clk);
    rst = 0;
    chk("rst_hour", curHour, 0);
    chk("rst_sec", curSec, 0);
    chk("rst_state", set_state, 0);
    run_en = 1;
    run_watch(12, t, sb, h, m, s);
    chk("t1_ticks", t, 3);
    chk("t1_sec", curSec, 3);
    chk("t1_min", curMin, 0);
    // preload 13:59 and count through the hour
    press(1, 0); incs(13); press(1, 0); incs(59); press(1, 0);
    chk("t2_sec_after_exit", curSec, 0);
    run_watch(244, t, sb, h, m, s);
    chk("t2_strobes", sb, 1);
    chk("t2_hour", h, 14);
    chk("t2_min", m, 0);
    chk("t2_sec", s, 0);
    // preload 23:59 and wrap the day
    press(1, 0); incs(9); press(1, 0); incs(59); press(1, 0);
    run_watch(244, t, sb, h, m, s);
    chk("t3_strobes", sb, 1);
    chk("t3_hour", h, 0);
    chk("t3_min", m, 0);
    // 25 increments of hour wrap to 1 with no ticks
    press(1, 0);
    run_watch(1, t, sb, h, m, s);
    t = 0;
    for (int k = 0; k < 25; k++) begin
      press(0, 1);
      if (sec_tick) t++;
    end
    chk("t4_hour", curHour, 1);
    chk("t4_min", curMin, 0);
    chk("t4_ticks", t, 0);
    // minute to 10, then mode+inc together
    press(1, 0); incs(10);
    chk("t5_min_set", curMin, 10);
    press(1, 1);
    chk("t5_state", set_state, 0);
    chk("t5_min", curMin, 10);
    chk("t5_sec", curSec, 0);
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("t5_no_tick_early", sec_tick, 0);
    @(negedge clk);
    chk("t5_tick", sec_tick, 1);
    // 07:33 in SET_MIN, then asynchronous reset
    press(1, 0); incs(6); press(1, 0); incs(23);
    chk("t6_hour_set", curHour, 7);
    chk("t6_min_set", curMin, 33);
    chk("t6_state_set", set_state, 2);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("t6_hour", curHour, 0);
    chk("t6_min", curMin, 0);
    chk("t6_sec", curSec, 0);
    chk("t6_state", set_state, 0);
    chk("t6_tick", sec_tick, 0);
    chk("t6_strobe", hour_strobe, 0);
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 10; k++) @(negedge clk);
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
